// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Two-port arbiter and sequencer in front of the SDRAM controller.
// Requester 0 (VGA line fetch) and requester 1 (core/cache) share a single
// read/write request interface. Grants are round-robin. One transaction is
// in flight at a time. The arbiter waits for the controller's event on the
// granted bank, then closes the row. A watchdog aborts a transaction that
// waits too long.
//
// Optional feature: define OPEN_ROW_EN to keep the row open when the other
// port is already waiting on the same bank and row.
//
// State table:
//   state   | meaning
//   IDLE    | no transaction; pick the next requester
//   ISSUE   | one-cycle ram_request_read/write pulse with latched bank/addr
//   WAIT    | grant held; wait for ram_event on the latched bank or timeout
//   CLOSE   | one-cycle done (+err) pulse and ram_close pulse
//
// Parameters:
//   ADDR_BITS          width of ram_addr and the requester address buses
//   TIMEOUT            maximum WAIT cycles before aborting (1..255)
//
// Ports:
//   clk, rst_n         system clock; synchronous active-low reset
//   reqN_read/write    level requests from requester N (write wins)
//   reqN_bank/addr     bank and address of requester N
//   reqN_grant         high while requester N owns the RAM
//   reqN_done          one-cycle pulse when requester N's transaction ends
//   err                one-cycle pulse with done when the transaction timed out
//   busy               high whenever the arbiter is not idle
//   ram_request_*      read/write strobe to the RAM controller
//   ram_bank_sel/addr  latched bank and address to the RAM controller
//   ram_close          one-cycle row-close pulse
//   ram_event(_bank)   controller completion report and the bank it refers to

module ram_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_read,
    input  logic                 req0_write,
    input  logic [1:0]           req0_bank,
    input  logic [ADDR_BITS-1:0] req0_addr,
    output logic                 req0_grant,
    output logic                 req0_done,

    input  logic                 req1_read,
    input  logic                 req1_write,
    input  logic [1:0]           req1_bank,
    input  logic [ADDR_BITS-1:0] req1_addr,
    output logic                 req1_grant,
    output logic                 req1_done,

    output logic                 err,
    output logic                 busy,

    output logic                 ram_request_read,
    output logic                 ram_request_write,
    output logic [1:0]           ram_bank_sel,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_close,
    input  logic                 ram_event,
    input  logic [1:0]           ram_event_bank
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_CLOSE = 2'd3;

    // WAIT closes on the cycle where the counter has already counted
    // TIMEOUT-1 idle cycles, so WAIT lasts exactly TIMEOUT cycles.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]           r_state;
    logic                 r_port;      // owner of the current transaction
    logic                 r_op;        // 1 = write, 0 = read
    logic [1:0]           r_bank;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_err;
    logic [7:0]           r_cnt;
    logic                 r_last;      // port granted most recently

    logic                 w_pend0;
    logic                 w_pend1;
    logic                 w_pick1;
    logic                 w_ev_hit;

    logic [1:0]           w_state_nxt;
    logic                 w_port_nxt;
    logic                 w_op_nxt;
    logic [1:0]           w_bank_nxt;
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic                 w_err_nxt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_last_nxt;
    logic                 w_keep_nxt;  // skip ram_close and chain into ISSUE

`ifdef OPEN_ROW_EN
    // Follow-up transaction captured when CLOSE is entered, so that the
    // decision to skip ram_close and the transaction issued next agree.
    logic                 r_keep;
    logic                 r_nop;
    logic [ADDR_BITS-1:0] r_naddr;

    logic                 w_oth_pend;
    logic                 w_oth_op;
    logic [1:0]           w_oth_bank;
    logic [ADDR_BITS-1:0] w_oth_addr;
    logic                 w_row_hit;
    logic                 w_nop_nxt;
    logic [ADDR_BITS-1:0] w_naddr_nxt;
`endif

    assign w_pend0  = req0_read | req0_write;
    assign w_pend1  = req1_read | req1_write;
    // Port 1 wins when it is the only one pending, or when both are pending
    // and port 0 was served last.
    assign w_pick1  = w_pend1 & (~w_pend0 | ~r_last);
    assign w_ev_hit = ram_event & (ram_event_bank == r_bank);

`ifdef OPEN_ROW_EN
    assign w_oth_pend = r_port ? w_pend0    : w_pend1;
    assign w_oth_op   = r_port ? req0_write : req1_write;
    assign w_oth_bank = r_port ? req0_bank  : req1_bank;
    assign w_oth_addr = r_port ? req0_addr  : req1_addr;
    assign w_row_hit  = w_oth_pend
                      & (w_oth_bank == r_bank)
                      & (w_oth_addr[ADDR_BITS-1:8] == r_addr[ADDR_BITS-1:8]);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_port;
        w_op_nxt    = r_op;
        w_bank_nxt  = r_bank;
        w_addr_nxt  = r_addr;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_keep_nxt  = 1'b0;
`ifdef OPEN_ROW_EN
        w_nop_nxt   = r_nop;
        w_naddr_nxt = r_naddr;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_pend0 || w_pend1) begin
                    w_state_nxt = S_ISSUE;
                    w_port_nxt  = w_pick1;
                    w_last_nxt  = w_pick1;
                    w_op_nxt    = w_pick1 ? req1_write : req0_write;
                    w_bank_nxt  = w_pick1 ? req1_bank  : req0_bank;
                    w_addr_nxt  = w_pick1 ? req1_addr  : req0_addr;
                    w_err_nxt   = 1'b0;
                end
            end

            S_ISSUE: begin
                // Any ram_event seen here predates the request and is ignored.
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end

            S_WAIT: begin
                // The event is checked first so that an event landing on the
                // last allowed cycle still counts as success.
                if (w_ev_hit) begin
                    w_state_nxt = S_CLOSE;
                    w_err_nxt   = 1'b0;
`ifdef OPEN_ROW_EN
                    w_keep_nxt  = w_row_hit;
                    w_nop_nxt   = w_oth_op;
                    w_naddr_nxt = w_oth_addr;
`endif
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = S_CLOSE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end

            S_CLOSE: begin
`ifdef OPEN_ROW_EN
                if (r_keep) begin
                    // Row stays open: hand the RAM straight to the other port.
                    w_state_nxt = S_ISSUE;
                    w_port_nxt  = ~r_port;
                    w_last_nxt  = ~r_port;
                    w_op_nxt    = r_nop;
                    w_addr_nxt  = r_naddr;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so that each output
    // lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_port            <= 1'b0;
            r_op              <= 1'b0;
            r_bank            <= 2'd0;
            r_addr            <= '0;
            r_err             <= 1'b0;
            r_cnt             <= 8'd0;
            r_last            <= 1'b1;
`ifdef OPEN_ROW_EN
            r_keep            <= 1'b0;
            r_nop             <= 1'b0;
            r_naddr           <= '0;
`endif
            req0_grant        <= 1'b0;
            req0_done         <= 1'b0;
            req1_grant        <= 1'b0;
            req1_done         <= 1'b0;
            err               <= 1'b0;
            busy              <= 1'b0;
            ram_request_read  <= 1'b0;
            ram_request_write <= 1'b0;
            ram_close         <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_port            <= w_port_nxt;
            r_op              <= w_op_nxt;
            r_bank            <= w_bank_nxt;
            r_addr            <= w_addr_nxt;
            r_err             <= w_err_nxt;
            r_cnt             <= w_cnt_nxt;
            r_last            <= w_last_nxt;
`ifdef OPEN_ROW_EN
            r_keep            <= w_keep_nxt;
            r_nop             <= w_nop_nxt;
            r_naddr           <= w_naddr_nxt;
`endif
            req0_grant        <= (w_state_nxt != S_IDLE) & ~w_port_nxt;
            req1_grant        <= (w_state_nxt != S_IDLE) &  w_port_nxt;
            req0_done         <= (w_state_nxt == S_CLOSE) & ~w_port_nxt;
            req1_done         <= (w_state_nxt == S_CLOSE) &  w_port_nxt;
            err               <= (w_state_nxt == S_CLOSE) &  w_err_nxt;
            busy              <= (w_state_nxt != S_IDLE);
            ram_request_read  <= (w_state_nxt == S_ISSUE) & ~w_op_nxt;
            ram_request_write <= (w_state_nxt == S_ISSUE) &  w_op_nxt;
            ram_close         <= (w_state_nxt == S_CLOSE) & ~w_keep_nxt;
        end
    end

    assign ram_bank_sel = r_bank;
    assign ram_addr     = r_addr;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AB = 12;
    localparam int TO = 10;
`ifdef OPEN_ROW_EN
    localparam bit OPEN_ROW = 1'b1;
`else
    localparam bit OPEN_ROW = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req0_read, req0_write, req1_read, req1_write;
    logic [1:0]    req0_bank, req1_bank;
    logic [AB-1:0] req0_addr, req1_addr;
    logic          req0_grant, req0_done, req1_grant, req1_done;
    logic          err, busy;
    logic          ram_request_read, ram_request_write, ram_close;
    logic [1:0]    ram_bank_sel;
    logic [AB-1:0] ram_addr;
    logic          ram_event;
    logic [1:0]    ram_event_bank;

    wire [22:0] all_outs = {req0_grant, req0_done, req1_grant, req1_done, err, busy,
                            ram_request_read, ram_request_write, ram_close,
                            ram_bank_sel, ram_addr};

    ram_arbiter #(.ADDR_BITS(AB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_read(req0_read), .req0_write(req0_write), .req0_bank(req0_bank),
        .req0_addr(req0_addr), .req0_grant(req0_grant), .req0_done(req0_done),
        .req1_read(req1_read), .req1_write(req1_write), .req1_bank(req1_bank),
        .req1_addr(req1_addr), .req1_grant(req1_grant), .req1_done(req1_done),
        .err(err), .busy(busy),
        .ram_request_read(ram_request_read), .ram_request_write(ram_request_write),
        .ram_bank_sel(ram_bank_sel), .ram_addr(ram_addr), .ram_close(ram_close),
        .ram_event(ram_event), .ram_event_bank(ram_event_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_last = 1;

    // controller / requester emulation and transaction log
    bit       auto_ctl, auto_drop, drop_early;
    int       cd;
    logic [1:0] ev_bank;
    int lat_q[$];
    int iss_port[$], iss_op[$], iss_bank[$], iss_addr[$], iss_cyc[$];
    int dn_port[$], dn_cyc[$], dn_err[$], dn_close[$];
    int n_close, n_rd, n_wr;

    task automatic clear_log();
        lat_q.delete();
        iss_port.delete(); iss_op.delete(); iss_bank.delete(); iss_addr.delete(); iss_cyc.delete();
        dn_port.delete(); dn_cyc.delete(); dn_err.delete(); dn_close.delete();
        n_close = 0; n_rd = 0; n_wr = 0; cd = 0; ram_event = 1'b0;
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr,
                           input logic [1:0] b, input logic [AB-1:0] a);
        if (p == 0) begin
            req0_read = rd; req0_write = wr; req0_bank = b; req0_addr = a;
        end else begin
            req1_read = rd; req1_write = wr; req1_bank = b; req1_addr = a;
        end
    endtask

    task automatic drop_req(input int p);
        if (p == 0) begin req0_read = 1'b0; req0_write = 1'b0; end
        else        begin req1_read = 1'b0; req1_write = 1'b0; end
    endtask

    // Advance one clock, sample at the falling edge, log and react.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ram_request_read || ram_request_write) begin
            iss_port.push_back(int'(req1_grant));
            iss_op.push_back(int'(ram_request_write));
            iss_bank.push_back(int'(ram_bank_sel));
            iss_addr.push_back(int'(ram_addr));
            iss_cyc.push_back(cyc);
            cd = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            ev_bank = ram_bank_sel;
            if (drop_early) drop_req(int'(req1_grant));
        end
        if (ram_request_read)  n_rd++;
        if (ram_request_write) n_wr++;
        if (ram_close)         n_close++;
        if (req0_done || req1_done) begin
            dn_port.push_back(int'(req1_done));
            dn_cyc.push_back(cyc);
            dn_err.push_back(int'(err));
            dn_close.push_back(int'(ram_close));
            if (auto_drop) drop_req(int'(req1_done));
        end
        if (auto_ctl) begin
            ram_event = 1'b0;
            ram_event_bank = 2'($urandom_range(0, 3));
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    ram_event = 1'b1;
                    ram_event_bank = ev_bank;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_req(0); drop_req(1);
        ram_event = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        m_last = 1;
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 1'b1, 2'd3, 12'hFFF);
        set_req(1, 1'b1, 1'b0, 2'd1, 12'hABC);
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (all_outs !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        drop_req(0); drop_req(1);
        rst_n = 1'b1;
        m_last = 1;
        tick();
        checks++;
        if (busy !== 1'b0 || dn_port.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b dones=%0d expected busy=0 dones=0", busy, dn_port.size());
        end
    endtask

    task automatic test_single_read();
        int cs;
        clear_log();
        auto_ctl = 1; auto_drop = 1; drop_early = 0;
        lat_q.push_back(3);
        set_req(0, 1'b1, 1'b0, 2'd2, 12'h123);
        cs = cyc;
        for (int k = 0; k < 40 && dn_port.size() < 1; k++) tick();
        tick(); tick();
        checks++;
        if (dn_port.size() != 1 || iss_port.size() != 1) begin
            errors++;
            $display("FAIL single_count: dones=%0d issues=%0d expected 1 1", dn_port.size(), iss_port.size());
        end else begin
            checks++;
            if (iss_port[0] !== 0 || iss_op[0] !== 0 || iss_bank[0] !== 2 ||
                iss_addr[0] !== 'h123 || iss_cyc[0] !== cs + 1) begin
                errors++;
                $display("FAIL single_issue: port=%0d op=%0d bank=%0d addr=%h cyc=%0d expected 0 0 2 123 %0d",
                         iss_port[0], iss_op[0], iss_bank[0], iss_addr[0], iss_cyc[0], cs + 1);
            end
            checks++;
            if (dn_port[0] !== 0 || dn_cyc[0] !== cs + 4 || dn_err[0] !== 0 || dn_close[0] !== 1) begin
                errors++;
                $display("FAIL single_done: port=%0d cyc=%0d err=%0d close=%0d expected 0 %0d 0 1",
                         dn_port[0], dn_cyc[0], dn_err[0], dn_close[0], cs + 4);
            end
        end
        checks++;
        if (n_rd !== 1 || n_wr !== 0 || n_close !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pulses: rd=%0d wr=%0d close=%0d busy=%b expected 1 0 1 0",
                     n_rd, n_wr, n_close, busy);
        end
        m_last = 0;
    endtask

    task automatic test_simultaneous();
        int c0, c1, ep;
        do_reset();
        clear_log();
        auto_ctl = 1; auto_drop = 0; drop_early = 0;
        for (int t = 0; t < 4; t++) lat_q.push_back($urandom_range(2, 9));
        set_req(0, 1'b0, 1'b1, 2'd0, 12'h010);
        set_req(1, 1'b1, 1'b0, 2'd1, 12'h020);
        for (int k = 0; k < 120 && dn_port.size() < 4; k++) begin
            tick();
            if (dn_port.size() >= 4) begin drop_req(0); drop_req(1); end
        end
        drop_req(0); drop_req(1);
        tick(); tick(); tick();
        auto_drop = 1;
        checks++;
        if (dn_port.size() != 4 || iss_port.size() != 4) begin
            errors++;
            $display("FAIL simul_count: dones=%0d issues=%0d expected 4 4", dn_port.size(), iss_port.size());
        end else begin
            c0 = 0; c1 = 0;
            for (int t = 0; t < 4; t++) begin
                ep = (t % 2 == 0) ? 1 - m_last : m_last;
                checks++;
                if (iss_port[t] !== ep || iss_op[t] !== ((ep == 0) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL simul_grant%0d: port=%0d op=%0d expected %0d %0d",
                             t, iss_port[t], iss_op[t], ep, (ep == 0) ? 1 : 0);
                end
                if (dn_port[t] == 0) c0++; else c1++;
            end
            checks++;
            if (c0 !== 2 || c1 !== 2) begin
                errors++;
                $display("FAIL simul_dones: port0=%0d port1=%0d expected 2 2", c0, c1);
            end
        end
        m_last = 1;
    endtask

    task automatic test_wrong_bank();
        int c;
        clear_log();
        auto_ctl = 0; auto_drop = 1; drop_early = 0;
        ram_event = 1'b0;
        set_req(1, 1'b1, 1'b0, 2'd1, 12'($urandom_range(0, 4095)));
        tick();
        c = cyc;
        checks++;
        if (iss_port.size() != 1) begin
            errors++;
            $display("FAIL wrongbank_issue: issues=%0d expected 1", iss_port.size());
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 7) begin
                checks++;
                if (dn_port.size() != 0) begin
                    errors++;
                    $display("FAIL wrongbank_ignored: dones=%0d expected 0", dn_port.size());
                end
            end
            tick();
            ram_event      = (k == 1 || k == 6);
            ram_event_bank = (k == 1) ? 2'd3 : 2'd1;
        end
        ram_event = 1'b0;
        checks++;
        if (dn_port.size() != 1) begin
            errors++;
            $display("FAIL wrongbank_count: dones=%0d expected 1", dn_port.size());
        end else if (dn_port[0] !== 1 || dn_cyc[0] !== c + 7 || dn_err[0] !== 0) begin
            errors++;
            $display("FAIL wrongbank_done: port=%0d cyc=%0d err=%0d expected 1 %0d 0",
                     dn_port[0], dn_cyc[0], dn_err[0], c + 7);
        end
        m_last = 1;
    endtask

    task automatic test_timeout();
        int lats[4] = '{0, 1, TO + 1, TO + 2};
        int p, cs, ee;
        for (int i = 0; i < 4; i++) begin
            clear_log();
            auto_ctl = 1; auto_drop = 1; drop_early = 0;
            lat_q.push_back(lats[i]);
            p = $urandom_range(0, 1);
            set_req(p, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
            cs = cyc;
            ee = (lats[i] == TO + 1) ? 0 : 1;
            for (int k = 0; k < 40 && dn_port.size() < 1; k++) tick();
            checks++;
            if (dn_port.size() != 1) begin
                errors++;
                $display("FAIL timeout%0d_count: dones=%0d expected 1", i, dn_port.size());
            end else if (dn_port[0] !== p || dn_cyc[0] !== cs + 1 + TO + 1 ||
                         dn_err[0] !== ee || dn_close[0] !== 1) begin
                errors++;
                $display("FAIL timeout%0d_done: port=%0d cyc=%0d err=%0d close=%0d expected %0d %0d %0d 1",
                         i, dn_port[0], dn_cyc[0], dn_err[0], dn_close[0], p, cs + TO + 2, ee);
            end
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL timeout%0d_idle: busy=%b expected 0", i, busy);
            end
            m_last = p;
        end
    endtask

    task automatic test_reset_mid_wait();
        int cs;
        clear_log();
        auto_ctl = 1; auto_drop = 1; drop_early = 0;
        lat_q.push_back(0);
        set_req(0, 1'b0, 1'b1, 2'd3, 12'h5A5);
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        drop_req(0);
        tick();
        checks++;
        if (all_outs !== 23'd0 || dn_port.size() != 0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h dones=%0d expected 0 0", all_outs, dn_port.size());
        end
        tick();
        rst_n = 1'b1;
        m_last = 1;
        tick();
        checks++;
        if (dn_port.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nodone: dones=%0d busy=%b expected 0 0", dn_port.size(), busy);
        end
        clear_log();
        lat_q.push_back(5);
        set_req(0, 1'b1, 1'b0, 2'd2, 12'h777);
        cs = cyc;
        for (int k = 0; k < 30 && dn_port.size() < 1; k++) tick();
        tick();
        checks++;
        if (dn_port.size() != 1 || iss_port.size() != 1) begin
            errors++;
            $display("FAIL midreset_fresh_count: dones=%0d issues=%0d expected 1 1", dn_port.size(), iss_port.size());
        end else if (iss_cyc[0] !== cs + 1 || iss_addr[0] !== 'h777 || dn_cyc[0] !== cs + 6 || dn_err[0] !== 0) begin
            errors++;
            $display("FAIL midreset_fresh: iss=%0d addr=%h done=%0d err=%0d expected %0d 777 %0d 0",
                     iss_cyc[0], iss_addr[0], dn_cyc[0], dn_err[0], cs + 1, cs + 6);
        end
        m_last = 0;
    endtask

    task automatic test_open_row();
        logic [AB-1:0] a1s[2] = '{12'h3AA, 12'h4AA};
        bit keep;
        int cs, e_iss1, e_close;
        for (int i = 0; i < 2; i++) begin
            do_reset();
            clear_log();
            auto_ctl = 1; auto_drop = 1; drop_early = 0;
            lat_q.push_back(3); lat_q.push_back(3);
            set_req(0, 1'b1, 1'b0, 2'd0, 12'h345);
            set_req(1, 1'b0, 1'b1, 2'd0, a1s[i]);
            cs = cyc;
            keep = OPEN_ROW && (a1s[i][11:8] == 4'h3);
            e_iss1 = cs + 4 + (keep ? 1 : 2);
            e_close = keep ? 0 : 1;
            for (int k = 0; k < 40 && dn_port.size() < 2; k++) tick();
            tick(); tick();
            checks++;
            if (dn_port.size() != 2 || iss_port.size() != 2) begin
                errors++;
                $display("FAIL openrow%0d_count: dones=%0d issues=%0d expected 2 2", i, dn_port.size(), iss_port.size());
            end else if (dn_close[0] !== e_close || iss_cyc[1] !== e_iss1 || iss_port[1] !== 1 ||
                         iss_addr[1] !== int'(a1s[i]) || iss_op[1] !== 1 || n_close !== 1 + e_close) begin
                errors++;
                $display("FAIL openrow%0d: close0=%0d iss1=%0d port1=%0d addr1=%h closes=%0d expected %0d %0d 1 %h %0d",
                         i, dn_close[0], iss_cyc[1], iss_port[1], iss_addr[1], n_close,
                         e_close, e_iss1, a1s[i], 1 + e_close);
            end
            m_last = 1;
        end
    endtask

    task automatic test_random();
        int mask, n, cs, gap;
        int pp[2], la[2], e_iss[2], e_done[2], e_err[2], e_close[2];
        bit rdv[2], wrv[2], keep;
        logic [1:0] bk[2];
        logic [AB-1:0] ad[2];
        for (int r = 0; r < 12; r++) begin
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                wrv[p] = 1'($urandom_range(0, 1));
                rdv[p] = wrv[p] ? 1'($urandom_range(0, 1)) : 1'b1;
                bk[p]  = 2'($urandom_range(0, 3));
                ad[p]  = 12'($urandom_range(0, 4095));
            end
            if (mask == 3 && $urandom_range(0, 1) == 1) begin
                bk[1] = bk[0];
                ad[1] = {ad[0][11:8], 8'($urandom_range(0, 255))};
            end
            la[0] = $urandom_range(1, 13);
            la[1] = $urandom_range(1, 13);
            if (mask == 3) begin n = 2; pp[0] = 1 - m_last; pp[1] = m_last; end
            else begin n = 1; pp[0] = (mask == 2) ? 1 : 0; pp[1] = 1 - pp[0]; end

            clear_log();
            for (int t = 0; t < n; t++) lat_q.push_back(la[t]);
            auto_ctl = 1; auto_drop = 1;
            drop_early = 1'($urandom_range(0, 1));
            for (int p = 0; p < 2; p++)
                if ((mask & (1 << p)) != 0) set_req(p, rdv[p], wrv[p], bk[p], ad[p]);
            cs = cyc;

            e_iss[0] = cs + 1;
            for (int t = 0; t < 2; t++) begin
                e_err[t] = (la[t] >= 2 && la[t] <= TO + 1) ? 0 : 1;
                e_close[t] = 1;
            end
            gap = e_err[0] ? TO + 1 : la[0];
            e_done[0] = e_iss[0] + gap;
            keep = OPEN_ROW && n == 2 && e_err[0] == 0 && bk[0] == bk[1] && ad[0][11:8] == ad[1][11:8];
            if (keep) e_close[0] = 0;
            e_iss[1] = e_done[0] + (keep ? 1 : 2);
            gap = e_err[1] ? TO + 1 : la[1];
            e_done[1] = e_iss[1] + gap;

            for (int k = 0; k < 80 && dn_port.size() < n; k++) tick();
            tick(); tick();
            drop_early = 0;
            drop_req(0); drop_req(1);

            checks++;
            if (dn_port.size() != n || iss_port.size() != n) begin
                errors++;
                $display("FAIL rand%0d_count: dones=%0d issues=%0d expected %0d", r, dn_port.size(), iss_port.size(), n);
            end else begin
                for (int t = 0; t < n; t++) begin
                    checks++;
                    if (iss_port[t] !== pp[t] || iss_op[t] !== int'(wrv[pp[t]]) ||
                        iss_bank[t] !== int'(bk[pp[t]]) || iss_addr[t] !== int'(ad[pp[t]]) ||
                        iss_cyc[t] !== e_iss[t]) begin
                        errors++;
                        $display("FAIL rand%0d_issue%0d: port=%0d op=%0d bank=%0d addr=%h cyc=%0d expected %0d %0d %0d %h %0d",
                                 r, t, iss_port[t], iss_op[t], iss_bank[t], iss_addr[t], iss_cyc[t],
                                 pp[t], wrv[pp[t]], bk[pp[t]], ad[pp[t]], e_iss[t]);
                    end
                    checks++;
                    if (dn_port[t] !== pp[t] || dn_cyc[t] !== e_done[t] ||
                        dn_err[t] !== e_err[t] || dn_close[t] !== e_close[t]) begin
                        errors++;
                        $display("FAIL rand%0d_done%0d: port=%0d cyc=%0d err=%0d close=%0d expected %0d %0d %0d %0d",
                                 r, t, dn_port[t], dn_cyc[t], dn_err[t], dn_close[t],
                                 pp[t], e_done[t], e_err[t], e_close[t]);
                    end
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_idle: busy=%b expected 0", r, busy);
            end
            m_last = pp[n-1];
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_read = 1'b0; req0_write = 1'b0; req0_bank = 2'd0; req0_addr = '0;
        req1_read = 1'b0; req1_write = 1'b0; req1_bank = 2'd0; req1_addr = '0;
        ram_event = 1'b0; ram_event_bank = 2'd0;
        auto_ctl = 0; auto_drop = 1; drop_early = 0;
        clear_log();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_wrong_bank();
        test_timeout();
        test_reset_mid_wait();
        test_open_row();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the SDRAM controller (RAM instance).
- Shares the single read/write request interface between requester 0 (VGA line fetch) and requester 1 (core/cache).
- Grants round-robin, issues one transaction at a time, waits for the controller's event on the granted bank, then closes the row.
- Provides a per-requester done/error handshake with a watchdog timeout.

Parameters:
- ADDR_BITS, 12: width of ram_addr and the requester address buses.
- TIMEOUT, 255: maximum cycles in WAIT before aborting; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock; same clock as the RAM controller.
- rst_n  in  1  synchronous active-low reset.
- req0_read  in  1  requester 0 read request; level, held until req0_done.
- req0_write  in  1  requester 0 write request; level, held until req0_done.
- req0_bank  in  2  requester 0 bank select.
- req0_addr  in  ADDR_BITS  requester 0 address.
- req0_grant  out  1  high while requester 0 owns the RAM.
- req0_done  out  1  one-cycle pulse when requester 0's transaction ends.
- req1_read, req1_write, req1_bank, req1_addr, req1_grant, req1_done: same as port 0, for requester 1.
- err  out  1  one-cycle pulse coincident with done when the transaction timed out.
- busy  out  1  high whenever state != IDLE.
- ram_request_read  out  1  to RAM controller.
- ram_request_write  out  1  to RAM controller.
- ram_bank_sel  out  2  to RAM controller.
- ram_addr  out  ADDR_BITS  to RAM controller.
- ram_close  out  1  one-cycle row-close pulse to RAM controller.
- ram_event  in  1  controller reports that the operation is ready.
- ram_event_bank  in  2  bank the event refers to.

Behaviour:

Clock and reset:
- Single clock domain; all outputs registered.
- rst_n low at a clk edge sets state=IDLE, last_grant=1 (so requester 0 wins first), timeout counter=0.
- Outputs during reset: all grants, done, err, busy, ram_request_*, ram_close = 0; ram_bank_sel=0; ram_addr=0.
- Reset mid-transaction aborts it immediately with no done pulse; requesters must re-request.

Request decoding:
- Pending_n = reqN_read | reqN_write.
- If both read and write are high on one port, write wins.

States:
- IDLE:
  - If both ports are pending, grant the port != last_grant; otherwise grant the pending port.
  - Latch bank, address and op from the granted port; update last_grant; go ISSUE.
  - Nothing pending: stay in IDLE.
- ISSUE (1 cycle):
  - Assert reqN_grant and exactly one of ram_request_read/ram_request_write.
  - Drive the latched ram_bank_sel and ram_addr.
  - Go WAIT; clear the timeout counter.
- WAIT:
  - Grant stays high; ram_request_* low; bank and address held stable.
  - ram_event=1 with ram_event_bank == latched bank: go CLOSE.
  - Events on other banks are ignored.
  - Counter reaches TIMEOUT: go CLOSE with the error flag set.
- CLOSE (1 cycle):
  - Pulse ram_close and reqN_done; pulse err if the error flag is set.
  - Drop the grant at the end of the cycle; go IDLE.

Latency:
- Request first visible in IDLE at edge N: ram_request at N+1.
- Matching event at edge M: done and ram_close at M+1; IDLE at M+2.
- Back-to-back throughput: 3 cycles of overhead plus controller latency.

Requester rules:
- A requester that deasserts its request before done is still completed; the done pulse is delivered regardless.
- The requester must sample done and drop or renew its request in the next cycle. A request still high in IDLE is treated as a new transaction.

Boundary conditions:
- A ram_event arriving in the same cycle as ISSUE is ignored.
- A ram_event exactly at the timeout cycle counts as success (the event has priority over the timeout).

Optional Feature:
- Macro OPEN_ROW_EN.
- When defined:
  - In CLOSE, ram_close is suppressed if the other port is pending with the same bank and the same row (addr[ADDR_BITS-1:8]) as the finished transaction.
  - The arbiter goes directly to ISSUE for that port, saving the IDLE cycle, and updates last_grant.
  - After a timeout, ram_close is always pulsed.
- When undefined: ram_close is pulsed after every transaction, as described above.

Test Plan:
- Reset and single read:
  - Stimulus: rst_n low for 2 cycles, then req0_read=1, bank=2, addr=0x123; event bank=2 three cycles after ISSUE.
  - Required: ram_request_read pulses once with bank=2, addr=0x123; req0_done and ram_close pulse together; err=0.
- Simultaneous requests:
  - Stimulus: req0_write and req1_read both held high for 4 transactions.
  - Required: grants alternate 0,1,0,1; each port receives exactly 2 done pulses.
- Wrong-bank event:
  - Stimulus: req1 on bank 1 receives an event on bank 3, then an event on bank 1 five cycles later.
  - Required: the first event is ignored; done follows the second event by 1 cycle.
- Timeout:
  - Stimulus: TIMEOUT=10, no ram_event after ISSUE.
  - Required: done, err and ram_close pulse 11 cycles after ISSUE; state returns to IDLE and busy=0.
- Reset mid-WAIT:
  - Stimulus: rst_n low during WAIT.
  - Required: next cycle all outputs are 0 and no done pulse occurs; a fresh request is served normally.
- OPEN_ROW_EN:
  - Stimulus: req0 at bank 0, addr 0x345 and req1 at bank 0, addr 0x3AA, both pending.
  - Required: no ram_close between the two transactions; the second ISSUE occurs in the cycle right after the first done.
  - With req1 at addr 0x4AA instead: ram_close pulses.
